pack_head_gen: RTL

PACK_HEAD_GEN -- requirements
Module: pack_head_gen

---
 rtl/pack_head_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pack_head_gen.sv
// Packet header generator: on fire_head, snapshots timestamp/config and streams a fixed-order
// header byte-by-byte over a valid/ready interface, optionally followed by an XOR checksum.
`timescale 1ns/1ps
module pack_head_gen #(
  parameter logic [7:0]  VER      = 8'h51,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned HAS_CSUM = 1
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              fire_head,
  input  logic              abort,
  output logic              done_head,
  output logic              busy,
  output logic [7:0]        head_data,
  output logic              head_vld,
  input  logic              head_rdy,
  input  logic [31:0]       q_utc,
  input  logic [31:0]       q_ns,
  input  logic [7:0]        cfg_sample,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [LEN_W-1:0]  len_load
);

  localparam int unsigned HDR_LEN  = 13 + HAS_CSUM;
  localparam logic [3:0]  LAST_IDX = 4'(HDR_LEN - 1);
  localparam logic [3:0]  CSUM_IDX = 4'd13;

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_t;

  state_t      r_state, w_state_d;
  logic [3:0]  r_idx, w_idx_d;
  logic [7:0]  r_csum, w_csum_d;
  logic [7:0]  r_data, w_data_d;
  logic        r_vld, w_vld_d;
  logic [31:0] r_utc, r_ns;
  logic [7:0]  r_sample, r_ch;
  logic [15:0] r_len;

  logic        w_snap_en;
  logic        w_xfer;
  logic [3:0]  w_idx_inc;
  logic [7:0]  w_csum_upd;
  logic [7:0]  w_sel_byte;

  assign w_xfer     = r_vld & head_rdy;
  assign w_idx_inc  = r_idx + 4'd1;
  assign w_csum_upd = r_csum ^ r_data;

  // Byte following the one currently presented; the checksum folds in the byte leaving now.
  always_comb begin
    w_sel_byte = 8'h00;
    case (w_idx_inc)
      4'd0:    w_sel_byte = VER;
      4'd1:    w_sel_byte = r_sample;
      4'd2:    w_sel_byte = r_ch;
      4'd3:    w_sel_byte = r_len[15:8];
      4'd4:    w_sel_byte = r_len[7:0];
      4'd5:    w_sel_byte = r_utc[31:24];
      4'd6:    w_sel_byte = r_utc[23:16];
      4'd7:    w_sel_byte = r_utc[15:8];
      4'd8:    w_sel_byte = r_utc[7:0];
      4'd9:    w_sel_byte = r_ns[31:24];
      4'd10:   w_sel_byte = r_ns[23:16];
      4'd11:   w_sel_byte = r_ns[15:8];
      4'd12:   w_sel_byte = r_ns[7:0];
      4'd13:   w_sel_byte = w_csum_upd;
      default: w_sel_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_csum_d  = r_csum;
    w_data_d  = r_data;
    w_vld_d   = r_vld;
    w_snap_en = 1'b0;
    if (abort) begin
      w_state_d = StIdle;
      w_vld_d   = 1'b0;
      w_idx_d   = 4'd0;
      w_csum_d  = 8'h00;
    end else begin
      case (r_state)
        StIdle: begin
          if (fire_head) begin
            w_state_d = StSend;
            w_snap_en = 1'b1;
            w_idx_d   = 4'd0;
            w_csum_d  = 8'h00;
            w_data_d  = VER;
            w_vld_d   = 1'b1;
          end
        end
        StSend: begin
          if (w_xfer) begin
            if (r_idx != CSUM_IDX) w_csum_d = w_csum_upd;
            if (r_idx == LAST_IDX) begin
              w_state_d = StDone;
              w_vld_d   = 1'b0;
            end else begin
              w_idx_d  = w_idx_inc;
              w_data_d = w_sel_byte;
            end
          end
        end
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= 4'd0;
      r_csum   <= 8'h00;
      r_data   <= 8'h00;
      r_vld    <= 1'b0;
      r_utc    <= 32'h0;
      r_ns     <= 32'h0;
      r_sample <= 8'h00;
      r_ch     <= 8'h00;
      r_len    <= 16'h0;
    end else begin
      r_idx  <= w_idx_d;
      r_csum <= w_csum_d;
      r_data <= w_data_d;
      r_vld  <= w_vld_d;
      if (w_snap_en) begin
        r_utc    <= q_utc;
        r_ns     <= q_ns;
        r_sample <= cfg_sample;
        r_ch     <= 8'(cfg_ch);
        r_len    <= 16'(len_load);
      end
    end
  end

  assign head_data = r_data;
  assign head_vld  = r_vld;
  assign busy      = (r_state != StIdle);
  assign done_head = (r_state == StDone);

endmodule
